// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: program-order allocation, out-of-order writeback,
// one retirement per cycle. Optional operand query ports are enabled with `define ROB_QUERY_EN.
module reorder_buffer #(
    parameter int ROB_WIDTH = 4,
    parameter int WB_PORTS  = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rdy_in,
    input  logic                          alloc_valid,
    input  logic [2:0]                    alloc_op,
    input  logic [4:0]                    alloc_rd,
    output logic                          alloc_ready,
    output logic [ROB_WIDTH-1:0]          alloc_tag,
    input  logic [WB_PORTS-1:0]           wb_valid,
    input  logic [WB_PORTS*ROB_WIDTH-1:0] wb_tag,
    input  logic [WB_PORTS*32-1:0]        wb_data,
    input  logic [WB_PORTS*32-1:0]        wb_jump,
    input  logic [WB_PORTS-1:0]           wb_mispredict,
    output logic                          commit_reg_en,
    output logic [4:0]                    commit_rd,
    output logic [31:0]                   commit_wdata,
    output logic [ROB_WIDTH-1:0]          commit_tag,
    output logic                          commit_valid,
    output logic                          commit_store,
    output logic                          clear,
    output logic [31:0]                   clear_pc,
    output logic [ROB_WIDTH:0]            count
`ifdef ROB_QUERY_EN
    ,
    input  logic [2*ROB_WIDTH-1:0]        q_tag,
    output logic [1:0]                    q_ready,
    output logic [63:0]                   q_data
`endif
);

    localparam int ROB_SIZE = 1 << ROB_WIDTH;
    localparam logic [ROB_WIDTH:0] FULL_COUNT = ROB_SIZE[ROB_WIDTH:0];

    localparam logic [2:0] OP_WRITE   = 3'b000;
    localparam logic [2:0] OP_JUMP    = 3'b001;
    localparam logic [2:0] OP_BOTH    = 3'b010;
    localparam logic [2:0] OP_LS      = 3'b011;

    logic [ROB_WIDTH-1:0] head;
    logic [ROB_WIDTH-1:0] tail;
    logic [ROB_SIZE-1:0]  busy;
    logic [ROB_SIZE-1:0]  ready;

    // Payload arrays carry no reset; busy/ready qualify every read.
    logic [2:0]           op_q   [ROB_SIZE];
    logic [4:0]           rd_q   [ROB_SIZE];
    logic [31:0]          data_q [ROB_SIZE];
    logic [31:0]          jump_q [ROB_SIZE];
    logic [ROB_SIZE-1:0]  mis_q;

    logic [ROB_WIDTH-1:0] wb_tag_a  [WB_PORTS];
    logic [31:0]          wb_data_a [WB_PORTS];
    logic [31:0]          wb_jump_a [WB_PORTS];
    logic [WB_PORTS-1:0]  wb_hit;

    logic                 alloc_fire;
    logic                 commit_fire;
    logic [2:0]           head_op;
    logic [4:0]           head_rd;
    logic                 head_is_write;
    logic                 head_is_jump;
    logic                 head_redirect;
    logic [ROB_WIDTH:0]   count_next;

    always_comb begin
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_tag_a[p]  = wb_tag[p*ROB_WIDTH +: ROB_WIDTH];
            wb_data_a[p] = wb_data[p*32 +: 32];
            wb_jump_a[p] = wb_jump[p*32 +: 32];
        end
    end

    assign alloc_ready = (count < FULL_COUNT) && !clear;
    assign alloc_tag   = tail;

    // Everything arriving while clear is high is discarded along with the flush.
    assign alloc_fire  = rdy_in && alloc_valid && alloc_ready;
    assign commit_fire = rdy_in && !clear && (count != '0) && ready[head];

    always_comb begin
        wb_hit = '0;
        for (int p = 0; p < WB_PORTS; p++) begin
            wb_hit[p] = rdy_in && !clear && wb_valid[p] && busy[wb_tag_a[p]];
        end
    end

    assign head_op       = op_q[head];
    assign head_rd       = rd_q[head];
    assign head_is_write = (head_op == OP_WRITE) || (head_op == OP_BOTH);
    assign head_is_jump  = (head_op == OP_JUMP) || (head_op == OP_BOTH);
    assign head_redirect = head_is_jump && mis_q[head];

    always_comb begin
        case ({alloc_fire, commit_fire})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            busy          <= '0;
            ready         <= '0;
            commit_valid  <= 1'b0;
            commit_reg_en <= 1'b0;
            commit_store  <= 1'b0;
            commit_rd     <= '0;
            commit_wdata  <= '0;
            commit_tag    <= '0;
            clear         <= 1'b0;
            clear_pc      <= '0;
        end else if (rdy_in) begin
            commit_valid  <= 1'b0;
            commit_reg_en <= 1'b0;
            commit_store  <= 1'b0;
            clear         <= 1'b0;
            if (clear) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                busy  <= '0;
                ready <= '0;
            end else begin
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_hit[p]) begin
                        ready[wb_tag_a[p]] <= 1'b1;
                    end
                end
                // Retirement is ordered after writeback so a freed slot never stays ready.
                if (commit_fire) begin
                    head          <= head + 1'b1;
                    busy[head]    <= 1'b0;
                    ready[head]   <= 1'b0;
                    commit_valid  <= 1'b1;
                    commit_tag    <= head;
                    commit_rd     <= head_rd;
                    commit_wdata  <= data_q[head];
                    commit_reg_en <= head_is_write && (head_rd != 5'd0);
                    commit_store  <= (head_op == OP_LS);
                    if (head_redirect) begin
                        clear    <= 1'b1;
                        clear_pc <= jump_q[head];
                    end
                end
                if (alloc_fire) begin
                    tail        <= tail + 1'b1;
                    busy[tail]  <= 1'b1;
                    ready[tail] <= 1'b0;
                end
                count <= count_next;
            end
        end
    end

    // Later ports overwrite earlier ones, so the highest-index port wins a tag collision.
    always_ff @(posedge clk_in) begin
        for (int p = 0; p < WB_PORTS; p++) begin
            if (wb_hit[p]) begin
                data_q[wb_tag_a[p]] <= wb_data_a[p];
                jump_q[wb_tag_a[p]] <= wb_jump_a[p];
                mis_q[wb_tag_a[p]]  <= wb_mispredict[p];
            end
        end
        if (alloc_fire) begin
            op_q[tail] <= alloc_op;
            rd_q[tail] <= alloc_rd;
        end
    end

`ifdef ROB_QUERY_EN
    logic [ROB_WIDTH-1:0] q_tag_a [2];

    always_comb begin
        q_ready = '0;
        q_data  = '0;
        for (int q = 0; q < 2; q++) begin
            q_tag_a[q] = q_tag[q*ROB_WIDTH +: ROB_WIDTH];
            if (busy[q_tag_a[q]]) begin
                if (ready[q_tag_a[q]]) begin
                    q_ready[q]         = 1'b1;
                    q_data[q*32 +: 32] = data_q[q_tag_a[q]];
                end
                for (int p = 0; p < WB_PORTS; p++) begin
                    if (wb_valid[p] && (wb_tag_a[p] == q_tag_a[q])) begin
                        q_ready[q]         = 1'b1;
                        q_data[q*32 +: 32] = wb_data_a[p];
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, fill, out-of-order writeback, mispredict flush,
// wrap-around with simultaneous alloc/commit, and rdy_in stall.
module tb_reorder_buffer;

    localparam int W = 4;
    localparam int P = 2;

    localparam logic [2:0] OP_WRITE   = 3'b000;
    localparam logic [2:0] OP_BOTH    = 3'b010;
    localparam logic [2:0] OP_LS      = 3'b011;
    localparam logic [2:0] OP_NOTHING = 3'b100;

    logic            clk_in = 1'b0;
    logic            rst_in;
    logic            rdy_in;
    logic            alloc_valid;
    logic [2:0]      alloc_op;
    logic [4:0]      alloc_rd;
    logic            alloc_ready;
    logic [W-1:0]    alloc_tag;
    logic [P-1:0]    wb_valid;
    logic [P*W-1:0]  wb_tag;
    logic [P*32-1:0] wb_data;
    logic [P*32-1:0] wb_jump;
    logic [P-1:0]    wb_mispredict;
    logic            commit_reg_en;
    logic [4:0]      commit_rd;
    logic [31:0]     commit_wdata;
    logic [W-1:0]    commit_tag;
    logic            commit_valid;
    logic            commit_store;
    logic            clear;
    logic [31:0]     clear_pc;
    logic [W:0]      count;
`ifdef ROB_QUERY_EN
    logic [2*W-1:0]  q_tag = '0;
    logic [1:0]      q_ready;
    logic [63:0]     q_data;
`endif

    int n_checks = 0;
    int n_errors = 0;

    reorder_buffer #(.ROB_WIDTH(W), .WB_PORTS(P)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .alloc_valid(alloc_valid), .alloc_op(alloc_op), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .wb_jump(wb_jump), .wb_mispredict(wb_mispredict),
        .commit_reg_en(commit_reg_en), .commit_rd(commit_rd), .commit_wdata(commit_wdata),
        .commit_tag(commit_tag), .commit_valid(commit_valid), .commit_store(commit_store),
        .clear(clear), .clear_pc(clear_pc), .count(count)
`ifdef ROB_QUERY_EN
        , .q_tag(q_tag), .q_ready(q_ready), .q_data(q_data)
`endif
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        alloc_valid = 1'b0;
        wb_valid    = '0;
        rdy_in      = 1'b1;
        #2 rst_in   = 1'b1;
        #2 rst_in   = 1'b0;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1;
        alloc_valid = 1'b0; alloc_op = OP_WRITE; alloc_rd = '0;
        wb_valid = '0; wb_tag = '0; wb_data = '0; wb_jump = '0; wb_mispredict = '0;
        #12 rst_in = 1'b0;

        // T1: async reset mid-clock after some activity
        alloc_valid = 1'b1; alloc_op = OP_WRITE; alloc_rd = 5'd3;
        step(); step(); step();
        check("t1_count_pre", count, 3);
        #3 rst_in = 1'b1;
        #1;
        check("t1_count", count, 0);
        check("t1_alloc_ready", alloc_ready, 1);
        check("t1_alloc_tag", alloc_tag, 0);
        check("t1_commit_valid", commit_valid, 0);
        check("t1_clear", clear, 0);
        alloc_valid = 1'b0;
        #2 rst_in = 1'b0;

        // T2: fill all 16 entries, 17th ignored
        do_reset();
        alloc_valid = 1'b1; alloc_op = OP_NOTHING; alloc_rd = 5'd0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (i == 7) check("t2_tag_mid", alloc_tag, 8);
        end
        check("t2_count_full", count, 16);
        check("t2_alloc_ready", alloc_ready, 0);
        check("t2_tail_wrap", alloc_tag, 0);
        step();
        check("t2_count_17", count, 16);
        check("t2_tail_17", alloc_tag, 0);
        check("t2_no_commit", commit_valid, 0);
        alloc_valid = 1'b0;

        // T3: out-of-order writeback, in-order commit
        do_reset();
        alloc_valid = 1'b1; alloc_op = OP_WRITE; alloc_rd = 5'd5; step();
        alloc_rd = 5'd6; step();
        alloc_valid = 1'b0;
        wb_valid = 2'b10; wb_tag = {4'd1, 4'd0}; wb_data = {32'h22, 32'h0}; wb_mispredict = '0;
        step();
        check("t3_no_commit_a", commit_valid, 0);
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd0}; wb_data = {32'h0, 32'h11};
        step();
        wb_valid = '0;
        check("t3_no_commit_b", commit_valid, 0);
        step();
        check("t3_c0_valid", commit_valid, 1);
        check("t3_c0_tag", commit_tag, 0);
        check("t3_c0_rd", commit_rd, 5);
        check("t3_c0_data", commit_wdata, 32'h11);
        check("t3_c0_regen", commit_reg_en, 1);
        step();
        check("t3_c1_valid", commit_valid, 1);
        check("t3_c1_tag", commit_tag, 1);
        check("t3_c1_rd", commit_rd, 6);
        check("t3_c1_data", commit_wdata, 32'h22);
        step();
        check("t3_idle", commit_valid, 0);
        check("t3_count", count, 0);

        // T4: mispredicted BOTH flushes the younger WRITE
        do_reset();
        alloc_valid = 1'b1; alloc_op = OP_BOTH; alloc_rd = 5'd1; step();
        alloc_op = OP_WRITE; alloc_rd = 5'd2; step();
        alloc_valid = 1'b0;
        wb_valid = 2'b11; wb_tag = {4'd1, 4'd0};
        wb_data = {32'h77, 32'h8}; wb_jump = {32'h0, 32'h100}; wb_mispredict = 2'b01;
        step();
        wb_valid = '0; wb_mispredict = '0;
        step();
        check("t4_valid", commit_valid, 1);
        check("t4_regen", commit_reg_en, 1);
        check("t4_rd", commit_rd, 1);
        check("t4_data", commit_wdata, 32'h8);
        check("t4_clear", clear, 1);
        check("t4_clear_pc", clear_pc, 32'h100);
        check("t4_alloc_blocked", alloc_ready, 0);
        alloc_valid = 1'b1; alloc_op = OP_WRITE; alloc_rd = 5'd9;
        step();
        alloc_valid = 1'b0;
        check("t4_clear_off", clear, 0);
        check("t4_count", count, 0);
        check("t4_no_rd2", commit_valid, 0);
        check("t4_tail", alloc_tag, 0);
        step();
        check("t4_still_idle", commit_valid, 0);
        check("t4_clear_pc_hold", clear_pc, 32'h100);

        // T5: 15 in flight, alloc+commit every cycle across wrap
        do_reset();
        alloc_valid = 1'b1; alloc_op = OP_WRITE;
        for (int n = 0; n < 15; n++) begin
            alloc_rd = 5'((n % 31) + 1);
            step();
        end
        alloc_valid = 1'b0;
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd0}; wb_data = {32'h0, 32'h1000};
        step();
        check("t5_count_init", count, 15);
        for (int c = 0; c < 40; c++) begin
            alloc_valid = 1'b1;
            alloc_rd = 5'(((15 + c) % 31) + 1);
            wb_valid = 2'b01;
            wb_tag = {4'd0, 4'((c + 1) % 16)};
            wb_data = {32'h0, 32'h1000 + 32'(c + 1)};
            step();
            check("t5_valid", commit_valid, 1);
            check("t5_tag", commit_tag, 64'(c % 16));
            check("t5_data", commit_wdata, 64'(32'h1000 + c));
            check("t5_rd", commit_rd, 64'((c % 31) + 1));
            check("t5_count", count, 15);
        end
        alloc_valid = 1'b0; wb_valid = '0;

        // T6: rdy_in stall with ready head, port collision, rd=0 and LS commit
        do_reset();
        alloc_valid = 1'b1; alloc_op = OP_WRITE; alloc_rd = 5'd0; step();
        alloc_op = OP_LS; alloc_rd = 5'd3; step();
        alloc_valid = 1'b0;
        wb_valid = 2'b01; wb_tag = {4'd0, 4'd1}; wb_data = {32'h0, 32'h5};
        step();
        wb_valid = 2'b11; wb_tag = {4'd0, 4'd0}; wb_data = {32'hBB, 32'hAA};
        step();
        wb_valid = '0;
        rdy_in = 1'b0;
        alloc_valid = 1'b1; alloc_op = OP_WRITE; alloc_rd = 5'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t6_stall_commit", commit_valid, 0);
            check("t6_stall_count", count, 2);
        end
        alloc_valid = 1'b0;
        rdy_in = 1'b1;
        step();
        check("t6_c0_valid", commit_valid, 1);
        check("t6_c0_tag", commit_tag, 0);
        check("t6_c0_regen", commit_reg_en, 0);
        check("t6_c0_data", commit_wdata, 32'hBB);
        check("t6_c0_store", commit_store, 0);
        step();
        check("t6_c1_valid", commit_valid, 1);
        check("t6_c1_tag", commit_tag, 1);
        check("t6_c1_store", commit_store, 1);
        check("t6_c1_regen", commit_reg_en, 0);
        step();
        check("t6_idle", commit_valid, 0);
        check("t6_store_off", commit_store, 0);
        check("t6_count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
